// File: rtl/counter_parameter_checker.sv
// Watches three free-running counters and checks that each advances by exactly
// one per clock (mod 2^Wn); counts mismatch cycles and latches FAIL at MAX_ERR.
module counter_parameter_checker #(
    parameter int W1      = 8,
    parameter int W2      = 4,
    parameter int W3      = 3,
    parameter int ERR_W   = 8,
    parameter int MAX_ERR = 16
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             en,
    input  logic [W1-1:0]    counter1,
    input  logic [W2-1:0]    counter2,
    input  logic [W3-1:0]    counter3,
    output logic [1:0]       state,
    output logic             locked,
    output logic [2:0]       err_flags,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       wrap_pulse,
    output logic             fail
);

    // Handshake: none; en is a level qualifier sampled on every rising edge.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_CHECK = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [W1-1:0]      exp1_q, exp1_d;
    logic [W2-1:0]      exp2_q, exp2_d;
    logic [W3-1:0]      exp3_q, exp3_d;
    logic [2:0]         err_flags_q, err_flags_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [2:0]         wrap_q, wrap_d;
    logic [2:0]         mism;

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= S_IDLE;
            exp1_q      <= '0;
            exp2_q      <= '0;
            exp3_q      <= '0;
            err_flags_q <= '0;
            err_count_q <= '0;
            wrap_q      <= '0;
        end else begin
            state_q     <= state_d;
            exp1_q      <= exp1_d;
            exp2_q      <= exp2_d;
            exp3_q      <= exp3_d;
            err_flags_q <= err_flags_d;
            err_count_q <= err_count_d;
            wrap_q      <= wrap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        exp1_d      = exp1_q;
        exp2_d      = exp2_q;
        exp3_d      = exp3_q;
        err_flags_d = err_flags_q;
        err_count_d = err_count_q;
        wrap_d      = '0;
        mism        = '0;
        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_SYNC;
            end
            S_SYNC: begin
                exp1_d  = counter1 + W1'(1);
                exp2_d  = counter2 + W2'(1);
                exp3_d  = counter3 + W3'(1);
                state_d = en ? S_CHECK : S_IDLE;
            end
            S_CHECK: begin
                // Dropping en leaves CHECK without sampling, so a jump that
                // coincides with the drop is not reported.
                if (!en) begin
                    state_d = S_IDLE;
                end else begin
                    mism[0]   = (counter1 != exp1_q);
                    mism[1]   = (counter2 != exp2_q);
                    mism[2]   = (counter3 != exp3_q);
                    wrap_d[0] = (exp1_q == '0) && (counter1 == '0);
                    wrap_d[1] = (exp2_q == '0) && (counter2 == '0);
                    wrap_d[2] = (exp3_q == '0) && (counter3 == '0);
                    exp1_d    = counter1 + W1'(1);
                    exp2_d    = counter2 + W2'(1);
                    exp3_d    = counter3 + W3'(1);
                    if (|mism) begin
                        err_flags_d = err_flags_q | mism;
                        if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
                        if (32'(err_count_d) >= 32'(MAX_ERR)) state_d = S_FAIL;
                    end
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state      = state_q;
    assign locked     = (state_q == S_CHECK);
    assign fail       = (state_q == S_FAIL);
    assign err_flags  = err_flags_q;
    assign err_count  = err_count_q;
    assign wrap_pulse = wrap_q;

endmodule
